// File: rtl/hht_arb_pkg.sv
// Shared types and defaults for the HHT memory arbiter: requester tag encoding
// and the parameter defaults used by the top level.
package hht_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    COL  = 2'd2,
    VAL  = 2'd3
  } req_id_e;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Response tag to {cpu, col, val} one-hot valid vector.
  function automatic logic [2:0] tag_to_onehot(input req_id_e tag);
    logic [2:0] oh;
    case (tag)
      CPU:     oh = 3'b100;
      COL:     oh = 3'b010;
      VAL:     oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/hht_rr2_pick.sv
// Two-way round-robin picker for the HHT column/value channels. The pointer
// register names the preferred channel (0 = column, 1 = value).
module hht_rr2_pick (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic adv_i,
  output logic pick0_o,
  output logic pick1_o
);

  logic ptr_q;
  logic ptr_d;

  // Winner selection and pointer next state; after a grant the other channel becomes preferred.
  always_comb begin
    pick0_o = 1'b0;
    pick1_o = 1'b0;
    ptr_d   = ptr_q;
    if (req0_i && req1_i) begin
      pick0_o = ~ptr_q;
      pick1_o = ptr_q;
    end else begin
      pick0_o = req0_i;
      pick1_o = req1_i;
    end
    if (adv_i) begin
      ptr_d = pick0_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hht_mem_arbiter.sv
// Single-port memory read arbiter between the CPU and the two HHT fetch channels,
// with starvation forcing for HHT and a two-cycle tagged response pipeline.
module hht_mem_arbiter
  import hht_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              hht_en,
  input  logic              cpu_req,
  input  logic              col_req,
  input  logic              val_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] col_addr,
  input  logic [ADDR_W-1:0] val_addr,
  output logic              cpu_gnt,
  output logic              col_gnt,
  output logic              val_gnt,
  output logic              cpu_rvalid,
  output logic              col_rvalid,
  output logic              val_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        col_m_s;
  logic        val_m_s;
  logic        hht_any_s;
  logic        force_s;
  logic        rr_col_s;
  logic        rr_val_s;
  logic        hht_gnt_s;
  req_id_e     gnt_tag_s;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  req_id_e     tag_q;
  logic [2:0]  rv_q;
  logic [DATA_W-1:0] rdata_q;

  assign col_m_s   = col_req & hht_en;
  assign val_m_s   = val_req & hht_en;
  assign hht_any_s = col_m_s | val_m_s;
  assign force_s   = (starve_q == LIMIT);
  assign hht_gnt_s = col_gnt | val_gnt;

  hht_rr2_pick u_rr (
    .clk_i   (Clk),
    .rst_ni  (Rst),
    .req0_i  (col_m_s),
    .req1_i  (val_m_s),
    .adv_i   (hht_gnt_s),
    .pick0_o (rr_col_s),
    .pick1_o (rr_val_s)
  );

  // Grant selection; everything is held at zero while reset is asserted.
  always_comb begin
    cpu_gnt   = 1'b0;
    col_gnt   = 1'b0;
    val_gnt   = 1'b0;
    gnt_tag_s = NONE;
    if (!Rst) begin
      gnt_tag_s = NONE;
    end else if (hht_any_s && (!cpu_req || force_s)) begin
      col_gnt   = rr_col_s;
      val_gnt   = rr_val_s;
      gnt_tag_s = rr_col_s ? COL : VAL;
    end else if (cpu_req) begin
      cpu_gnt   = 1'b1;
      gnt_tag_s = CPU;
    end else begin
      gnt_tag_s = NONE;
    end
  end

  // Memory port address mux.
  always_comb begin
    mem_rd   = cpu_gnt | col_gnt | val_gnt;
    mem_addr = '0;
    case (gnt_tag_s)
      CPU:     mem_addr = cpu_addr;
      COL:     mem_addr = col_addr;
      VAL:     mem_addr = val_addr;
      default: mem_addr = '0;
    endcase
  end

  // Starvation counter next state: counts CPU wins while HHT waits, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (hht_gnt_s || !hht_any_s) begin
      starve_d = 4'd0;
    end else if (cpu_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter and response pipeline registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      starve_q <= 4'd0;
      tag_q    <= NONE;
      rv_q     <= 3'b000;
      rdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      tag_q    <= gnt_tag_s;
      rv_q     <= tag_to_onehot(tag_q);
      if (tag_q != NONE) begin
        rdata_q <= mem_rdata;
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  assign cpu_rvalid = rv_q[2];
  assign col_rvalid = rv_q[1];
  assign val_rvalid = rv_q[0];
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_hht_mem_arbiter.sv
// Directed bench for hht_mem_arbiter: a table of per-cycle vectors plus
// hand-written starvation and mid-flight reset sequences.
module tb_hht_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        hht_en = 1'b0;
  logic        cpu_req = 1'b0, col_req = 1'b0, val_req = 1'b0;
  logic [31:0] cpu_addr = 32'd0, col_addr = 32'd0, val_addr = 32'd0;
  logic        cpu_gnt, col_gnt, val_gnt;
  logic        cpu_rvalid, col_rvalid, val_rvalid;
  logic [31:0] rdata;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;

  int n_chk = 0;
  int n_fail = 0;
  logic        pend_v = 1'b0;
  logic [31:0] pend_a = 32'd0;

  hht_mem_arbiter dut (
    .Clk(Clk), .Rst(Rst), .hht_en(hht_en),
    .cpu_req(cpu_req), .col_req(col_req), .val_req(val_req),
    .cpu_addr(cpu_addr), .col_addr(col_addr), .val_addr(val_addr),
    .cpu_gnt(cpu_gnt), .col_gnt(col_gnt), .val_gnt(val_gnt),
    .cpu_rvalid(cpu_rvalid), .col_rvalid(col_rvalid), .val_rvalid(val_rvalid),
    .rdata(rdata), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  // Memory contents seen by the arbiter.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'd180) return 32'd6;
    else if (a == 32'd2) return 32'd46;
    else return a + 32'd1000;
  endfunction

  typedef struct {
    logic        cpu, col, val, en;
    logic [31:0] ca, la, va;
    logic [2:0]  eg;
    logic [31:0] ea;
    logic [2:0]  erv;
    logic [31:0] ed;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge; memory answers one cycle after mem_rd.
  task automatic apply(input logic rst, input logic c, input logic l, input logic v, input logic en,
                       input logic [31:0] ca, input logic [31:0] la, input logic [31:0] va);
    @(negedge Clk);
    Rst = rst;
    cpu_req = c; col_req = l; val_req = v; hht_en = en;
    cpu_addr = ca; col_addr = la; val_addr = va;
    mem_rdata = pend_v ? memf(pend_a) : 32'hDEAD_BEEF;
    #1;
    pend_v = mem_rd;
    pend_a = mem_addr;
  endtask

  task automatic chk_out(input string nm, input logic [2:0] eg, input logic [31:0] ea,
                         input logic [2:0] erv, input logic [31:0] ed, input logic chk_d);
    chk({nm, " gnt"}, 32'({cpu_gnt, col_gnt, val_gnt}), 32'(eg));
    chk({nm, " mem_rd"}, 32'(mem_rd), 32'(|eg));
    chk({nm, " mem_addr"}, mem_addr, ea);
    chk({nm, " rvalid"}, 32'({cpu_rvalid, col_rvalid, val_rvalid}), 32'(erv));
    if (chk_d) chk({nm, " rdata"}, rdata, ed);
  endtask

  initial begin
    // cpu  col  val  en    ca       la       va     eg      ea       erv     ed
    vt[0]  = '{1'b0,1'b0,1'b0,1'b1, 32'd0,  32'd0,  32'd0, 3'b000, 32'd0,   3'b000, 32'd0};
    vt[1]  = '{1'b0,1'b1,1'b1,1'b1, 32'd0,  32'd181,32'd2, 3'b010, 32'd181, 3'b000, 32'd0};
    vt[2]  = '{1'b0,1'b1,1'b1,1'b1, 32'd0,  32'd181,32'd2, 3'b001, 32'd2,   3'b000, 32'd0};
    vt[3]  = '{1'b0,1'b1,1'b1,1'b1, 32'd0,  32'd181,32'd2, 3'b010, 32'd181, 3'b010, 32'd1181};
    vt[4]  = '{1'b0,1'b1,1'b1,1'b1, 32'd0,  32'd181,32'd2, 3'b001, 32'd2,   3'b001, 32'd46};
    vt[5]  = '{1'b0,1'b0,1'b0,1'b1, 32'd0,  32'd0,  32'd0, 3'b000, 32'd0,   3'b010, 32'd1181};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b1, 32'd0,  32'd0,  32'd0, 3'b000, 32'd0,   3'b001, 32'd46};
    vt[7]  = '{1'b0,1'b1,1'b0,1'b1, 32'd0,  32'd180,32'd0, 3'b010, 32'd180, 3'b000, 32'd0};
    vt[8]  = '{1'b0,1'b0,1'b0,1'b1, 32'd0,  32'd0,  32'd0, 3'b000, 32'd0,   3'b000, 32'd0};
    vt[9]  = '{1'b0,1'b0,1'b0,1'b1, 32'd0,  32'd0,  32'd0, 3'b000, 32'd0,   3'b010, 32'd6};
    vt[10] = '{1'b0,1'b1,1'b1,1'b1, 32'd0,  32'd181,32'd2, 3'b001, 32'd2,   3'b000, 32'd0};
    vt[11] = '{1'b0,1'b1,1'b1,1'b0, 32'd0,  32'd181,32'd2, 3'b000, 32'd0,   3'b000, 32'd0};
    vt[12] = '{1'b1,1'b1,1'b1,1'b0, 32'd126,32'd181,32'd2, 3'b100, 32'd126, 3'b001, 32'd46};
    vt[13] = '{1'b0,1'b1,1'b1,1'b0, 32'd0,  32'd181,32'd2, 3'b000, 32'd0,   3'b000, 32'd0};
    vt[14] = '{1'b0,1'b0,1'b0,1'b1, 32'd0,  32'd0,  32'd0, 3'b000, 32'd0,   3'b100, 32'd1126};
    vt[15] = '{1'b1,1'b1,1'b1,1'b1, 32'd126,32'd181,32'd2, 3'b100, 32'd126, 3'b000, 32'd0};
    vt[16] = '{1'b0,1'b1,1'b1,1'b1, 32'd0,  32'd181,32'd2, 3'b010, 32'd181, 3'b000, 32'd0};
    vt[17] = '{1'b0,1'b0,1'b0,1'b1, 32'd0,  32'd0,  32'd0, 3'b000, 32'd0,   3'b100, 32'd1126};
    vt[18] = '{1'b0,1'b0,1'b0,1'b1, 32'd0,  32'd0,  32'd0, 3'b000, 32'd0,   3'b010, 32'd1181};

    // Requests during reset must not produce any grant or response.
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd126, 32'd181, 32'd2);
      chk_out($sformatf("reset%0d", i), 3'b000, 32'd0, 3'b000, 32'd0, 1'b1);
    end

    for (int i = 0; i < 19; i++) begin
      apply(1'b1, vt[i].cpu, vt[i].col, vt[i].val, vt[i].en, vt[i].ca, vt[i].la, vt[i].va);
      chk_out($sformatf("v%0d", i), vt[i].eg, vt[i].ea, vt[i].erv, vt[i].ed, |vt[i].erv);
    end

    // CPU and column held: column forced through every fifth cycle.
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd126, 32'd182, 32'd0);
      chk($sformatf("starve%0d gnt", k), 32'({cpu_gnt, col_gnt, val_gnt}),
          (k % 5 == 4) ? 32'd2 : 32'd4);
      chk($sformatf("starve%0d addr", k), mem_addr, (k % 5 == 4) ? 32'd182 : 32'd126);
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    chk_out("drain", 3'b000, 32'd0, 3'b010, 32'd1182, 1'b1);

    // Reset one cycle after a CPU grant discards the in-flight response.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd126, 32'd0, 32'd0);
    chk_out("rst_pre", 3'b100, 32'd126, 3'b000, 32'd0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd126, 32'd0, 32'd0);
    chk_out("rst_mid", 3'b000, 32'd0, 3'b000, 32'd0, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd181, 32'd2);
    chk_out("rst_rel0", 3'b010, 32'd181, 3'b000, 32'd0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    chk_out("rst_rel1", 3'b000, 32'd0, 3'b000, 32'd0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    chk_out("rst_rel2", 3'b000, 32'd0, 3'b010, 32'd1181, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hht_mem_arbiter.md
HHT_MEM_ARBITER -- requirements
Module: hht_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of every requester and the memory port.
REQ-002 Parameter: DATA_W, 32, read-data width.
REQ-003 Parameter: STARVE_LIMIT, 4, consecutive CPU-won cycles after which a waiting HHT channel is forced through (legal range 1..15).
REQ-004 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: Rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: hht_en  input  1  HHT channels eligible for grant when 1.
REQ-007 Port: cpu_req, col_req, val_req  input  1 each  read request from CPU, HHT column-index fetch, HHT vector-value fetch.
REQ-008 Port: cpu_addr, col_addr, val_addr  input  ADDR_W each  request address, held stable while req=1 and gnt=0.
REQ-009 Port: cpu_gnt, col_gnt, val_gnt  output  1 each  request accepted this cycle (combinational, one-hot or all zero).
REQ-010 Port: cpu_rvalid, col_rvalid, val_rvalid  output  1 each  registered, one-hot or zero, rdata belongs to that requester.
REQ-011 Port: rdata  output  DATA_W  registered read data, shared by all requesters.
REQ-012 Port: mem_rd  output  1  memory read strobe, equal to OR of all gnts.
REQ-013 Port: mem_addr  output  ADDR_W  address of the granted requester; 0 when mem_rd=0.
REQ-014 Port: mem_rdata  input  DATA_W  memory data, valid exactly one cycle after mem_rd.

Function
REQ-015 At most one grant per cycle; a request is accepted in the cycle req=1 and gnt=1.
REQ-016 col_req/val_req are masked when hht_en=0.
REQ-017 Default priority: CPU above both HHT channels.
REQ-018 Between col and val: 2-way round robin; rr_ptr selects the preferred channel, toggles to the other channel after each HHT grant, and is unchanged otherwise.
REQ-019 starve_cnt (4 bits): increments when any unmasked HHT req is pending and CPU is granted; clears on any HHT grant or when no unmasked HHT req is pending; saturates at STARVE_LIMIT.
REQ-020 When starve_cnt == STARVE_LIMIT, the round-robin HHT winner is granted over a pending CPU request.
REQ-021 Response tag pipeline: tag_q (NONE/CPU/COL/VAL) registers the granter at the cycle N edge; at the cycle N+1 edge, rdata <= mem_rdata and the matching rvalid <= 1 (tag_q NONE gives all rvalid 0, rdata holds).
REQ-022 Latency is 2 cycles: a grant in cycle N gives rvalid in cycle N+2; back-to-back grants give back-to-back rvalids in grant order.
REQ-023 Deasserting hht_en mid-stream blocks new HHT grants only; up to 2 in-flight HHT responses are still delivered.
REQ-024 Simultaneous cpu/col/val requests with starve_cnt < STARVE_LIMIT: CPU is granted, starve_cnt increments, and rr_ptr is unchanged.

Reset
REQ-025 While Rst=0: all rvalid=0, rdata=0, tag pipeline NONE, rr_ptr=COL, starve_cnt=0; in-flight responses are discarded, with no rvalid after release.
REQ-026 gnt, mem_rd and mem_addr are forced to 0 while Rst=0.
REQ-027 The first grant is possible in the first cycle after Rst rises.

Structure
REQ-028 Package hht_arb_pkg holds: the 2-bit requester enum (NONE, CPU, COL, VAL), the default STARVE_LIMIT, and the ADDR_W/DATA_W defaults.
REQ-029 One sub-module, hht_rr2_pick (2-way round-robin picker with pointer register), is used for the col/val choice; all else is inline.

Verification
REQ-030 Only col_req, addr 180, mem_rdata 6 -> col_gnt in cycle 0, mem_addr=180, col_rvalid with rdata=6 in cycle 2.
REQ-031 col_req and val_req held for 4 cycles (addr 181, 2) -> grants alternate COL, VAL, COL, VAL; rvalids follow in the same order 2 cycles later.
REQ-032 cpu_req (126) and col_req (182) held continuously, STARVE_LIMIT=4 -> cpu granted 4 cycles, col granted 5th cycle, starve_cnt returns to 0.
REQ-033 val grant then hht_en=0 next cycle -> no further HHT grants; the in-flight val_rvalid still arrives with data 46 (addr 2).
REQ-034 Rst asserted one cycle after a cpu grant -> no cpu_rvalid after release, all outputs 0, rr_ptr=COL.
